// File: rtl/bitbakery_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : bitbakery_input_conditioner_if
// Description : Pin-side and core-side signal bundle of the BitBakery input
//               conditioner.
//               master : board / stimulus side (drives the raw pins, observes
//                        the conditioned outputs)
//               slave  : conditioner side (reads the raw pins, drives the
//                        conditioned outputs)
//               Signals:
//                 botoes_in[6:0]    raw game buttons, active-low, asynchronous
//                 iniciar_in        raw start key, active-low, asynchronous
//                 botoes[6:0]       debounced button levels, active-high
//                 botoes_pulse[6:0] one-cycle pulse per accepted press
//                 iniciar           debounced start level, active-high
//                 iniciar_pulse     one-cycle pulse per accepted start press
//                 jogada_valid      one-cycle "button pressed" event
//                 jogada_idx[2:0]   lowest pressed button behind jogada_valid
// Revision    : 1.0 - initial release
// ============================================================================
interface bitbakery_input_conditioner_if;
  logic [6:0] botoes_in;
  logic       iniciar_in;
  logic [6:0] botoes;
  logic [6:0] botoes_pulse;
  logic       iniciar;
  logic       iniciar_pulse;
  logic       jogada_valid;
  logic [2:0] jogada_idx;

  modport master (
    output botoes_in,
    output iniciar_in,
    input  botoes,
    input  botoes_pulse,
    input  iniciar,
    input  iniciar_pulse,
    input  jogada_valid,
    input  jogada_idx
  );

  modport slave (
    input  botoes_in,
    input  iniciar_in,
    output botoes,
    output botoes_pulse,
    output iniciar,
    output iniciar_pulse,
    output jogada_valid,
    output jogada_idx
  );
endinterface
`default_nettype wire

// File: rtl/bitbakery_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : bitbakery_input_conditioner
// Description : Synchronizes, debounces and edge-detects the seven active-low
//               game buttons and the active-low start key of the BitBakery
//               board, and encodes the lowest freshly pressed game button.
//               Ports:
//                 clock_in  system clock, rising edge
//                 reset_in  synchronous reset, active-low
//                 bus       bitbakery_input_conditioner_if.slave
//                           (raw pins in, conditioned levels/pulses/event out)
//               Parameters:
//                 DEBOUNCE  stable cycles needed to accept a level change (>= 1)
//                 CW        debounce counter width, 2**CW > DEBOUNCE
// Revision    : 1.0 - initial release
// ============================================================================
module bitbakery_input_conditioner #(
  parameter int DEBOUNCE = 50000,
  parameter int CW       = 16
) (
  input  wire logic                      clock_in,
  input  wire logic                      reset_in,
  bitbakery_input_conditioner_if.slave   bus
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  // Channel state encoded as {st, counting}
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } chan_state_t;

  // Channel 7 is the start key; pins are inverted so 1 means pressed.
  logic [7:0] raw;
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] st;
  logic [7:0] pulse;

  assign raw = ~{bus.iniciar_in, bus.botoes_in};

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_chan
    chan_state_t   state;
    chan_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rise_nxt;
    logic          pulse_q;

    always_ff @(posedge clock_in) begin
      if (!reset_in) begin
        state   <= RELEASED;
        cnt     <= '0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        pulse_q <= rise_nxt;
      end
    end

    // Any cycle where the synchronized level agrees with the stable state
    // drops the count, so a bounce shorter than DEBOUNCE never completes.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      rise_nxt  = 1'b0;
      if (s2[i] == state[1]) begin
        state_nxt = state[1] ? PRESSED : RELEASED;
      end else if (cnt == CNT_MAX) begin
        state_nxt = s2[i] ? PRESSED : RELEASED;
        rise_nxt  = s2[i];
      end else begin
        state_nxt = s2[i] ? PRESS_WAIT : RELEASE_WAIT;
        cnt_nxt   = cnt + CW'(1);
      end
    end

    assign st[i]    = state[1];
    assign pulse[i] = pulse_q;
  end

  // Lowest-index game button among the current pulses; the start key is
  // deliberately excluded from the encoder.
  logic [2:0] lowest_idx;

  always_comb begin
    lowest_idx = 3'd0;
    for (int j = 6; j >= 0; j--) begin
      if (pulse[j]) begin
        lowest_idx = 3'(j);
      end
    end
  end

  logic       jogada_valid_q;
  logic [2:0] jogada_idx_q;

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      jogada_valid_q <= 1'b0;
      jogada_idx_q   <= 3'd0;
    end else begin
      jogada_valid_q <= |pulse[6:0];
      if (|pulse[6:0]) begin
        jogada_idx_q <= lowest_idx;
      end
    end
  end

  assign bus.botoes        = st[6:0];
  assign bus.botoes_pulse  = pulse[6:0];
  assign bus.iniciar       = st[7];
  assign bus.iniciar_pulse = pulse[7];
  assign bus.jogada_valid  = jogada_valid_q;
  assign bus.jogada_idx    = jogada_idx_q;

endmodule
`default_nettype wire
